// File: rtl/rotary_pkg.sv
// rotary_pkg: shared definitions for the quadrature transmitter.
//   dir_e       step direction (DIR_INC=1, DIR_DEC=0)
//   PHn_AB      {A,B} level for each of the four quadrature phases
//   phase_next  next phase index one step in the given direction
//   phase_ab    phase index -> {A,B}
package rotary_pkg;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } dir_e;

  localparam logic [1:0] PH0_AB = 2'b00;
  localparam logic [1:0] PH1_AB = 2'b01;
  localparam logic [1:0] PH2_AB = 2'b11;
  localparam logic [1:0] PH3_AB = 2'b10;

  // Two-bit arithmetic wraps mod 4, giving the Gray-coded cycle for free.
  function automatic logic [1:0] phase_next(input logic [1:0] phase, input dir_e dir);
    logic [1:0] nxt;
    if (dir == DIR_INC) nxt = phase + 2'd1;
    else                nxt = phase - 2'd1;
    return nxt;
  endfunction

  function automatic logic [1:0] phase_ab(input logic [1:0] phase);
    logic [1:0] ab;
    case (phase)
      2'd0: ab = PH0_AB;
      2'd1: ab = PH1_AB;
      2'd2: ab = PH2_AB;
      2'd3: ab = PH3_AB;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/rotary_tx_pacer.sv
// rotary_tx_pacer: reloadable down-counter that spaces quadrature transitions.
//   clk, resetn  clock / synchronous active-low reset
//   load         reload counter with DIV-1 (takes priority over tick)
//   tick         decrement by one, holding at zero
//   zero         counter is at zero
module rotary_tx_pacer
  #(
    parameter int unsigned DIV = 1000
  )
  (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic tick,
    output logic zero
  );

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rotary_tx.sv
// rotary_tx: quadrature waveform generator. Accepts single-step inc/dec
// requests into a signed pending accumulator and emits one Gray-code AB
// transition per pending step, no faster than one every DIV clocks.
//   clk, resetn   clock / synchronous active-low reset
//   step_valid    step request (transfers when step_valid && step_ready)
//   step_dir      1 = increment, 0 = decrement
//   step_ready    accumulator can accept a step (registered)
//   quadA, quadB  quadrature outputs (registered)
//   busy          pending steps outstanding (registered)
//   position      12-bit emitted-step position, only with ROTARY_TX_POSITION_EN
module rotary_tx
  import rotary_pkg::*;
  #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned CNT_W = 8
  )
  (
    input  logic        clk,
    input  logic        resetn,
    input  logic        step_valid,
    input  logic        step_dir,
    output logic        step_ready,
    output logic        quadA,
    output logic        quadB,
    output logic        busy
`ifdef ROTARY_TX_POSITION_EN
    ,
    output logic [11:0] position
`endif
  );

  localparam logic signed [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic signed [CNT_W-1:0] PMAX     = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic signed [CNT_W-1:0] NEG_PMAX = -PMAX;

  logic signed [CNT_W-1:0] pending;
  logic signed [CNT_W-1:0] pendingNext;
  logic signed [CNT_W-1:0] stepDelta;
  logic signed [CNT_W-1:0] emitDelta;
  logic [1:0] phase;
  logic [1:0] phaseNext;
  logic       accept;
  logic       emit;
  logic       divZero;
  logic       posDir;
  dir_e       emitDir;

  rotary_tx_pacer #(.DIV(DIV)) uPacer (
    .clk    (clk),
    .resetn (resetn),
    .load   (emit),
    .tick   (1'b1),
    .zero   (divZero)
  );

  assign accept    = step_valid && step_ready;
  assign emit      = (pending != '0) && divZero;
  assign posDir    = !pending[CNT_W-1];
  assign emitDir   = posDir ? DIR_INC : DIR_DEC;
  assign phaseNext = phase_next(phase, emitDir);

  // Accept and emit are applied together; an emit always moves pending toward zero.
  always_comb begin
    stepDelta = '0;
    emitDelta = '0;
    if (accept) stepDelta = step_dir ? ONE : -ONE;
    if (emit)   emitDelta = posDir ? ONE : -ONE;
    pendingNext = pending + stepDelta - emitDelta;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending    <= '0;
      phase      <= 2'd0;
      quadA      <= 1'b0;
      quadB      <= 1'b0;
      step_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      pending <= pendingNext;
      // Ready looks at the post-update value so it never depends on this
      // cycle's step_dir; either limit blocks both directions.
      step_ready <= (pendingNext != PMAX) && (pendingNext != NEG_PMAX);
      busy       <= (pendingNext != '0);
      if (emit) begin
        phase          <= phaseNext;
        {quadA, quadB} <= phase_ab(phaseNext);
      end
    end
  end

`ifdef ROTARY_TX_POSITION_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      position <= '0;
    end else if (emit) begin
      position <= posDir ? position + 12'd1 : position - 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rotary_tx.sv
module tb_rotary_tx;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic step_valid = 1'b0;
  logic step_dir = 1'b0;
  logic step_ready, quadA, quadB, busy;
`ifdef ROTARY_TX_POSITION_EN
  logic [11:0] position;
`endif

  rotary_tx #(.DIV(4), .CNT_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .quadA      (quadA),
    .quadB      (quadB),
    .busy       (busy)
`ifdef ROTARY_TX_POSITION_EN
    ,
    .position   (position)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   decCount = 0;
  bit   monOn = 1'b0;
  logic [1:0] prevAB = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] phAb(input int ph);
    logic [1:0] t [4];
    t[0] = 2'b00; t[1] = 2'b01; t[2] = 2'b11; t[3] = 2'b10;
    return t[ph % 4];
  endfunction

  function automatic int abPh(input logic [1:0] ab);
    int p;
    case (ab)
      2'b00: p = 0;
      2'b01: p = 1;
      2'b11: p = 2;
      default: p = 3;
    endcase
    return p;
  endfunction

  task automatic push(input logic [1:0] ab, input int c);
    exp_t e;
    e.ab = ab;
    e.cyc = c;
    expQ.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Monitor: every observed AB change must match the next queued expectation,
  // both in value and in the edge on which it appears.
  always @(negedge clk) begin
    logic [1:0] cur;
    exp_t e;
    int d;
    cur = {quadA, quadB};
    if (monOn && (cur !== prevAB)) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL ab_unexpected got=%b cyc=%0d want=no_change", cur, cyc);
      end else begin
        e = expQ.pop_front();
        if (e.ab !== cur || e.cyc != cyc) begin
          errors++;
          $display("FAIL ab_seq got=%b@%0d want=%b@%0d", cur, cyc, e.ab, e.cyc);
        end
      end
      d = (abPh(cur) - abPh(prevAB) + 4) % 4;
      if (d == 1) decCount++;
      else if (d == 3) decCount--;
    end
    prevAB = cur;
  end

  task automatic doReset(input bit expectChange);
    @(negedge clk);
    resetn = 1'b0;
    step_valid = 1'b0;
    if (expectChange) push(2'b00, cyc + 1);
    @(negedge clk);
    chk("rst_ab", int'({quadA, quadB}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(step_ready), 1);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (busy !== 1'b0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy === 1'b0), 1);
    repeat (3) @(negedge clk);
    chk("queue_drained", expQ.size(), 0);
  endtask

  initial begin
    int E;
    doReset(1'b0);
    monOn = 1'b1;

    // Three back-to-back increments: 01,11,10 at E+1,E+5,E+9.
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b1;
    push(2'b01, E + 1);
    push(2'b11, E + 5);
    push(2'b10, E + 9);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 2) step_valid = 1'b0;
      chk("t1_busy", int'(busy), (i < 9) ? 1 : 0);
    end
    waitIdle(50);

    // Four decrements from 00: 10,11,01,00; decoder net -4.
    doReset(1'b1);
    decCount = 0;
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b0;
    push(2'b10, E + 1);
    push(2'b11, E + 5);
    push(2'b01, E + 9);
    push(2'b00, E + 13);
    for (int i = 0; i < 4; i++) @(negedge clk);
    step_valid = 1'b0;
    waitIdle(50);
    chk("t2_decoder_net", decCount, -4);

    // Saturation: valid held 10 cycles, only 9 accepted.
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b1;
    for (int k = 0; k < 9; k++) push(phAb(k + 1), E + 1 + 4 * k);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_ready", int'(step_ready), (i == 9) ? 0 : 1);
    end
    @(negedge clk);
    step_valid = 1'b0;
    chk("t3_ready_back", int'(step_ready), 1);
    chk("t3_busy", int'(busy), 1);
    waitIdle(100);

    // pending=+1 with a decrement on the emit cycle: 11 then back to 01.
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b1;
    push(2'b11, E + 1);
    push(2'b01, E + 5);
    @(negedge clk);
    step_dir = 1'b0;
    @(negedge clk);
    step_valid = 1'b0;
    chk("t4_busy_mid", int'(busy), 1);
    repeat (5) @(negedge clk);
    chk("t4_busy_end", int'(busy), 0);
    chk("t4_ab_final", int'({quadA, quadB}), 1);
    waitIdle(20);

    // Reset mid-burst with pending=5, AB=11.
    doReset(1'b1);
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b1;
    push(2'b01, E + 1);
    push(2'b11, E + 5);
    push(2'b00, E + 7);
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("t5_busy_pre", int'(busy), 1);
    chk("t5_ab_pre", int'({quadA, quadB}), 3);
    step_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_ab_rst", int'({quadA, quadB}), 0);
    chk("t5_busy_rst", int'(busy), 0);
    chk("t5_ready_rst", int'(step_ready), 1);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_busy_quiet", int'(busy), 0);
    chk("t5_queue", expQ.size(), 0);

`ifdef ROTARY_TX_POSITION_EN
    chk("pos_reset", int'(position), 0);
    @(negedge clk);
    E = cyc + 1;
    step_valid = 1'b1;
    step_dir = 1'b0;
    push(2'b10, E + 1);
    push(2'b11, E + 5);
    push(2'b01, E + 9);
    push(2'b00, E + 13);
    push(2'b10, E + 17);
    for (int i = 0; i < 5; i++) @(negedge clk);
    step_valid = 1'b0;
    waitIdle(50);
    chk("pos_after_5dec", int'(position), 4091);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
